period_gen: RTL and testbench

Period generator for one emulated clock domain: produces the per-edge time increment `inc` consumed by the clock's period-progression logic, advancing once per `time_eq`. Adds a programmable nominal period, a bounded pseudo-random jitter (LFSR) and a fractional frequency offset (drift accumulator), with saturation. Sits directly upstream of the clock gating/progression stage, one instance per emulated clock.

---
 rtl/period_gen.sv | 150 +++++++++++++++
 tb/tb_period_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/period_gen.sv
`default_nettype none
// ============================================================================
// Module   : period_gen
// Purpose  : Per-edge time increment generator for one emulated clock.
//            inc = clamp(period + drift carry + LFSR jitter, 1, 2^W-1),
//            advanced once per time_eq strobe.
// Revision : 1.0 - initial release
// ============================================================================
module period_gen #(
  parameter int          TIME_INC_BITS = 16,
  parameter int          JITTER_BITS   = 8,
  parameter int          FRAC_BITS     = 16,
  parameter int          RESET_PERIOD  = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  input  logic [TIME_INC_BITS-1:0]   cfg_period,
  input  logic [JITTER_BITS-1:0]     cfg_jitter_mask,
  input  logic signed [FRAC_BITS:0]  cfg_drift,
  input  logic                       time_eq,
  output logic [TIME_INC_BITS-1:0]   inc,
  output logic                       cfg_applied,
  output logic                       sat
);

  localparam int W = TIME_INC_BITS;
  localparam int J = JITTER_BITS;
  localparam int F = FRAC_BITS;
  // Arithmetic width with headroom for period + carry + jitter offset.
  localparam int c_RAW_W = ((W > J) ? W : J) + 3;

  localparam logic [15:0]            c_LFSR_TAPS   = 16'hB400;
  localparam logic [W-1:0]           c_RESET_INC   = W'(RESET_PERIOD);
  localparam logic signed [F:0]      c_DRIFT_MIN   = {1'b1, {F{1'b0}}};
  localparam logic signed [F:0]      c_DRIFT_LIM   = {1'b1, {(F-1){1'b0}}, 1'b1};
  localparam logic signed [c_RAW_W-1:0] c_INC_MIN  = c_RAW_W'(1);
  localparam logic signed [c_RAW_W-1:0] c_INC_MAX  = {{(c_RAW_W-W){1'b0}}, {W{1'b1}}};
  localparam logic signed [c_RAW_W-1:0] c_ONE      = c_RAW_W'(1);
  localparam logic signed [c_RAW_W-1:0] c_MINUS1   = {c_RAW_W{1'b1}};

  logic [W-1:0]            r_period_s;
  logic [J-1:0]            r_mask_s;
  logic signed [F:0]       r_drift_s;
  logic                    r_pend;
  logic [15:0]             r_lfsr;
  logic [F-1:0]            r_acc;
  logic [W-1:0]            r_inc;
  logic                    r_cfg_applied;
  logic                    r_sat;

  logic [W-1:0]            w_period_e;
  logic [J-1:0]            w_mask_e;
  logic signed [F:0]       w_drift_e;
  logic signed [F:0]       w_drift_lim;
  logic [15:0]             w_lfsr_nxt;
  logic [J-1:0]            w_j;
  logic signed [c_RAW_W-1:0] w_offset;
  logic signed [F+1:0]     w_sum;
  logic signed [c_RAW_W-1:0] w_d;
  logic signed [c_RAW_W-1:0] w_raw;
  logic [W-1:0]            w_inc_nxt;
  logic                    w_sat_nxt;

  // A write in the advance cycle bypasses the shadow registers.
  assign w_period_e  = cfg_valid ? cfg_period      : r_period_s;
  assign w_mask_e    = cfg_valid ? cfg_jitter_mask : r_mask_s;
  assign w_drift_e   = cfg_valid ? cfg_drift       : r_drift_s;
  // The most negative drift is pulled in by one so |drift| < 2^F holds.
  assign w_drift_lim = (w_drift_e == c_DRIFT_MIN) ? c_DRIFT_LIM : w_drift_e;

  // Galois LFSR, right shift; jitter uses the post-step value.
  assign w_lfsr_nxt  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
  assign w_j         = w_lfsr_nxt[J-1:0] & w_mask_e;
  // Centre the jitter around zero: offset = j - (mask >> 1).
  assign w_offset    = $signed({{(c_RAW_W-J){1'b0}}, w_j})
                     - $signed({{(c_RAW_W-J+1){1'b0}}, w_mask_e[J-1:1]});

  // Fractional drift accumulator; overflow/underflow yields a +/-1 carry.
  assign w_sum       = $signed({2'b00, r_acc}) + $signed({w_drift_lim[F], w_drift_lim});

  // Carry decode and saturating clamp of the raw increment.
  always_comb begin
    w_d       = '0;
    w_inc_nxt = '0;
    w_sat_nxt = 1'b0;
    if (w_sum[F+1]) begin
      w_d = c_MINUS1;
    end else if (w_sum[F]) begin
      w_d = c_ONE;
    end
    w_raw = $signed({{(c_RAW_W-W){1'b0}}, w_period_e}) + w_d + w_offset;
    if (w_raw < c_INC_MIN) begin
      w_inc_nxt = W'(1);
      w_sat_nxt = 1'b1;
    end else if (w_raw > c_INC_MAX) begin
      w_inc_nxt = {W{1'b1}};
      w_sat_nxt = 1'b1;
    end else begin
      w_inc_nxt = w_raw[W-1:0];
    end
  end

  // Shadow config and pending-write flag; a bypassing advance consumes the write.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_period_s <= c_RESET_INC;
      r_mask_s   <= '0;
      r_drift_s  <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (cfg_valid) begin
        r_period_s <= cfg_period;
        r_mask_s   <= cfg_jitter_mask;
        r_drift_s  <= cfg_drift;
      end
      if (time_eq) begin
        r_pend <= 1'b0;
      end else if (cfg_valid) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Advance state: LFSR, accumulator, increment and one-cycle status pulses.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr        <= LFSR_SEED;
      r_acc         <= '0;
      r_inc         <= c_RESET_INC;
      r_cfg_applied <= 1'b0;
      r_sat         <= 1'b0;
    end else begin
      r_cfg_applied <= time_eq & (r_pend | cfg_valid);
      r_sat         <= time_eq & w_sat_nxt;
      if (time_eq) begin
        r_lfsr <= w_lfsr_nxt;
        r_acc  <= w_sum[F-1:0];
        r_inc  <= w_inc_nxt;
      end
    end
  end

  assign inc         = r_inc;
  assign cfg_applied = r_cfg_applied;
  assign sat         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_period_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_period_gen
// Purpose  : Self-checking bench for period_gen against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_period_gen;

  localparam int W = 16;
  localparam int J = 8;
  localparam int F = 16;

  logic                clk_sys = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_valid = 1'b0;
  logic [W-1:0]        cfg_period = '0;
  logic [J-1:0]        cfg_jitter_mask = '0;
  logic signed [F:0]   cfg_drift = '0;
  logic                time_eq = 1'b0;
  logic [W-1:0]        inc;
  logic                cfg_applied;
  logic                sat;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_lfsr, m_acc, m_pend, m_sp, m_sm, m_sd;
  int e_inc, e_app, e_sat;

  period_gen #(
    .TIME_INC_BITS(W), .JITTER_BITS(J), .FRAC_BITS(F),
    .RESET_PERIOD(100), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_valid(cfg_valid),
    .cfg_period(cfg_period), .cfg_jitter_mask(cfg_jitter_mask),
    .cfg_drift(cfg_drift), .time_eq(time_eq),
    .inc(inc), .cfg_applied(cfg_applied), .sat(sat)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 'hACE1; m_acc = 0; m_pend = 0;
    m_sp = 100; m_sm = 0; m_sd = 0;
    e_inc = 100; e_app = 0; e_sat = 0;
  endtask

  task automatic model_step(input bit cv, input int p, input int m, input int dr, input bit te);
    int pe, me, de, off, sum, d, raw;
    if (te) begin
      pe = cv ? p : m_sp;
      me = cv ? m : m_sm;
      de = cv ? dr : m_sd;
      if (de == -(1 << F)) de = -(1 << F) + 1;
      if ((m_lfsr & 1) != 0) m_lfsr = (m_lfsr >> 1) ^ 'hB400;
      else                   m_lfsr = m_lfsr >> 1;
      off = (m_lfsr & me) - (me >> 1);
      sum = m_acc + de;
      if (sum >= (1 << F)) begin d = 1;  m_acc = sum - (1 << F); end
      else if (sum < 0)    begin d = -1; m_acc = sum + (1 << F); end
      else                 begin d = 0;  m_acc = sum; end
      raw = pe + d + off;
      if (raw < 1)                    begin e_inc = 1;              e_sat = 1; end
      else if (raw > (1 << W) - 1)    begin e_inc = (1 << W) - 1;   e_sat = 1; end
      else                            begin e_inc = raw;            e_sat = 0; end
      e_app  = (m_pend != 0 || cv) ? 1 : 0;
      m_pend = 0;
    end else begin
      e_app = 0;
      e_sat = 0;
      if (cv) m_pend = 1;
    end
    if (cv) begin m_sp = p; m_sm = m; m_sd = dr; end
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic cycle(input bit cv, input int p, input int m, input int dr, input bit te);
    cfg_valid       = cv;
    cfg_period      = p[W-1:0];
    cfg_jitter_mask = m[J-1:0];
    cfg_drift       = dr[F:0];
    time_eq         = te;
    @(posedge clk_sys);
    model_step(cv, p, m, dr, te);
    @(negedge clk_sys);
    chk("inc", inc, e_inc);
    chk("cfg_applied", cfg_applied, e_app);
    chk("sat", sat, e_sat);
  endtask

  initial begin
    int adv, p, m, dr, sel;
    model_reset();
    repeat (3) @(negedge clk_sys);
    chk("rst_inc", inc, 100);
    chk("rst_applied", cfg_applied, 0);
    chk("rst_sat", sat, 0);
    rst_n = 1'b1;

    // Idle after reset: inc holds RESET_PERIOD
    repeat (10) cycle(0, 0, 0, 0, 0);

    // Config write then single-cycle advances
    cycle(1, 250, 0, 0, 0);
    repeat (3) begin
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
    end

    // Positive drift: 100,100,100,101 pattern
    cycle(1, 100, 0, 16384, 0);
    repeat (8) cycle(0, 0, 0, 0, 1);

    // Negative drift, then bypass write with advance in the same cycle
    cycle(1, 100, 0, -32768, 0);
    repeat (6) cycle(0, 0, 0, 0, 1);
    cycle(1, 300, 0, -32768, 1);
    repeat (4) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // Jitter window with random advance pattern
    cycle(1, 1000, 'h0F, 0, 0);
    adv = 0;
    while (adv < 1000) begin
      bit te;
      te = ($urandom_range(0, 3) != 0);
      cycle(0, $urandom_range(0, 65535), $urandom_range(0, 255), 0, te);
      if (te) begin
        adv++;
        chk("jit_range", (inc >= 993 && inc <= 1008) ? 1 : 0, 1);
      end
    end

    // Random configurations including extremes and drift limits
    repeat (300) begin
      sel = $urandom_range(0, 3);
      p   = (sel == 0) ? $urandom_range(0, 3) :
            (sel == 1) ? $urandom_range(65530, 65535) : $urandom_range(0, 65535);
      m   = $urandom_range(0, 255);
      sel = $urandom_range(0, 3);
      dr  = (sel == 0) ? -65536 : (sel == 1) ? 65535 : int'($urandom_range(0, 131071)) - 65536;
      cycle(($urandom_range(0, 5) == 0), p, m, dr, $urandom_range(0, 1) != 0);
    end

    // Small period with full mask: low-side saturation
    cycle(1, 2, 'hFF, 0, 0);
    repeat (200) cycle(0, 0, 0, 0, 1);

    // Pending write, then asynchronous reset between clock edges
    cycle(1, 500, 0, 0, 0);
    cfg_valid = 1'b0;
    time_eq   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_inc", inc, 100);
    chk("async_rst_applied", cfg_applied, 0);
    chk("async_rst_sat", sat, 0);
    model_reset();
    @(negedge clk_sys);
    rst_n = 1'b1;
    // Pending write was discarded: no cfg_applied, reset shadow period used
    repeat (3) cycle(0, $urandom_range(0, 65535), 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
